// File: rtl/calculator_input_ctrl.sv
// Keypad/cursor input controller for the on-screen calculator: converts button
// edges into cursor moves and key actions, and latches operands for the ALU.

module calculator_input_ctrl_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       calc_go,
  input logic [2:0] pos_x
);
  // calc_go is a single-cycle pulse; the cursor never leaves the 6-column grid
  a_go_single: assert property (@(posedge clk) disable iff (!rst_n) calc_go |=> !calc_go);
  a_pos_x_range: assert property (@(posedge clk) disable iff (!rst_n) pos_x <= 3'd5);
endmodule

module calculator_input_ctrl #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_c,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        mode,
  input  logic [15:0] result,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [2:0]  op,
  output logic [15:0] input_screen,
  output logic        calc_go
);

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_RESULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    A_NONE  = 3'd0,
    A_KEY   = 3'd1,
    A_UP    = 3'd2,
    A_DOWN  = 3'd3,
    A_LEFT  = 3'd4,
    A_RIGHT = 3'd5
  } action_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  logic [4:0]  btn_s;
  logic [4:0]  btn_prev_r;
  logic [4:0]  evt_s;
  action_t     action_s;
  logic [4:0]  key_s;
  logic [3:0]  digit_s;
  logic        digit_ok_s;

  state_t      state_r,        state_nxt_s;
  logic [2:0]  pos_x_r,        pos_x_nxt_s;
  logic [1:0]  pos_y_r,        pos_y_nxt_s;
  logic [15:0] op1_r,          op1_nxt_s;
  logic [15:0] op2_r,          op2_nxt_s;
  logic [2:0]  op_r,           op_nxt_s;
  logic [15:0] input_screen_r, input_screen_nxt_s;
  logic [2:0]  count_r,        count_nxt_s;
  logic        calc_go_r,      calc_go_nxt_s;

  assign btn_s      = {btn_c, btn_u, btn_d, btn_l, btn_r};
  assign evt_s      = btn_s & ~btn_prev_r;
  assign key_s      = ({3'b000, pos_y_r} * 5'd6) + {2'b00, pos_x_r};
  assign digit_s    = key_s[3:0];
  assign digit_ok_s = (key_s < 5'd16) && (mode || (digit_s <= 4'd9));

  // Pick the single highest-priority event; the rest are dropped this cycle
  always_comb begin
    action_s = A_NONE;
    if (evt_s[4]) begin
      action_s = A_KEY;
    end else if (evt_s[3]) begin
      action_s = A_UP;
    end else if (evt_s[2]) begin
      action_s = A_DOWN;
    end else if (evt_s[1]) begin
      action_s = A_LEFT;
    end else if (evt_s[0]) begin
      action_s = A_RIGHT;
    end else begin
      action_s = A_NONE;
    end
  end

  // Next-state and next-output logic for cursor, entry buffer and operands
  always_comb begin
    state_nxt_s        = state_r;
    pos_x_nxt_s        = pos_x_r;
    pos_y_nxt_s        = pos_y_r;
    op1_nxt_s          = op1_r;
    op2_nxt_s          = op2_r;
    op_nxt_s           = op_r;
    input_screen_nxt_s = input_screen_r;
    count_nxt_s        = count_r;
    calc_go_nxt_s      = 1'b0;

    case (action_s)
      A_UP:    pos_y_nxt_s = pos_y_r - 2'd1;
      A_DOWN:  pos_y_nxt_s = pos_y_r + 2'd1;
      A_LEFT:  pos_x_nxt_s = (pos_x_r == 3'd0) ? 3'd5 : (pos_x_r - 3'd1);
      A_RIGHT: pos_x_nxt_s = (pos_x_r == 3'd5) ? 3'd0 : (pos_x_r + 3'd1);
      A_KEY: begin
        if (key_s < 5'd16) begin
          if (digit_ok_s) begin
            // A digit after a result starts a fresh first operand
            if (state_r == S_RESULT) begin
              input_screen_nxt_s = {12'h000, digit_s};
              count_nxt_s        = 3'd1;
              state_nxt_s        = S_OP1;
            end else if (count_r < MAX_CNT) begin
              input_screen_nxt_s = {input_screen_r[11:0], digit_s};
              count_nxt_s        = count_r + 3'd1;
            end else begin
              input_screen_nxt_s = input_screen_r;
            end
          end else begin
            count_nxt_s = count_r;
          end
        end else begin
          case (key_s)
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
              op_nxt_s = key_s[2:0];
              case (state_r)
                S_OP1: begin
                  op1_nxt_s          = input_screen_r;
                  input_screen_nxt_s = 16'h0000;
                  count_nxt_s        = 3'd0;
                  state_nxt_s        = S_OP2;
                end
                S_RESULT: begin
                  op1_nxt_s          = result;
                  input_screen_nxt_s = 16'h0000;
                  count_nxt_s        = 3'd0;
                  state_nxt_s        = S_OP2;
                end
                S_OP2:   state_nxt_s = S_OP2;
                default: state_nxt_s = S_OP1;
              endcase
            end
            5'd21: begin
              input_screen_nxt_s = 16'h0000;
              count_nxt_s        = 3'd0;
            end
            5'd22: begin
              input_screen_nxt_s = 16'h0000;
              count_nxt_s        = 3'd0;
              op1_nxt_s          = 16'h0000;
              op2_nxt_s          = 16'h0000;
              op_nxt_s           = 3'd0;
              state_nxt_s        = S_OP1;
            end
            5'd23: begin
              if (state_r == S_OP2) begin
                op2_nxt_s     = input_screen_r;
                calc_go_nxt_s = 1'b1;
                state_nxt_s   = S_RESULT;
              end else begin
                calc_go_nxt_s = 1'b0;
              end
            end
            default: calc_go_nxt_s = 1'b0;
          endcase
        end
      end
      default: calc_go_nxt_s = 1'b0;
    endcase
  end

  // State and output registers; buttons held through reset must not fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_r     <= 5'b11111;
      state_r        <= S_OP1;
      pos_x_r        <= 3'd0;
      pos_y_r        <= 2'd0;
      op1_r          <= 16'h0000;
      op2_r          <= 16'h0000;
      op_r           <= 3'd0;
      input_screen_r <= 16'h0000;
      count_r        <= 3'd0;
      calc_go_r      <= 1'b0;
    end else begin
      btn_prev_r     <= btn_s;
      state_r        <= state_nxt_s;
      pos_x_r        <= pos_x_nxt_s;
      pos_y_r        <= pos_y_nxt_s;
      op1_r          <= op1_nxt_s;
      op2_r          <= op2_nxt_s;
      op_r           <= op_nxt_s;
      input_screen_r <= input_screen_nxt_s;
      count_r        <= count_nxt_s;
      calc_go_r      <= calc_go_nxt_s;
    end
  end

  assign pos_x        = pos_x_r;
  assign pos_y        = pos_y_r;
  assign op1          = op1_r;
  assign op2          = op2_r;
  assign op           = op_r;
  assign input_screen = input_screen_r;
  assign calc_go      = calc_go_r;

  calculator_input_ctrl_checker u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .calc_go (calc_go_r),
    .pos_x   (pos_x_r)
  );

endmodule

// File: tb/tb_calculator_input_ctrl.sv
// Scoreboard bench for calculator_input_ctrl: random key/cursor stimulus checked
// against a digit-list reference model of the calculator entry rules.

module tb_calculator_input_ctrl;
  localparam int MAX_DIGITS = 4;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;
  localparam int PH_FIRST = 0, PH_SECOND = 1, PH_SHOWN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] result = 16'h0000;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic [15:0] op1, op2, input_screen;
  logic [2:0]  op;
  logic        calc_go;

  calculator_input_ctrl #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .mode(mode), .result(result),
    .pos_x(pos_x), .pos_y(pos_y), .op1(op1), .op2(op2), .op(op),
    .input_screen(input_screen), .calc_go(calc_go)
  );

  typedef struct { int x; int y; int op1; int op2; int op; int scr; } snap_t;
  snap_t exp_q[$];
  int    go_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  sample_req = 1'b0;
  logic  prev_go = 1'b0;

  // Reference model: cursor as grid coordinates, entry as a list of digits
  int mx, my, m_op1, m_op2, m_op, phase;
  int digits[$];

  function automatic int screen_val();
    int s = 0;
    foreach (digits[i]) s = s * 16 + digits[i];
    return s & 32'h0000FFFF;
  endfunction

  function automatic void model_reset();
    mx = 0; my = 0; m_op1 = 0; m_op2 = 0; m_op = 0; phase = PH_FIRST;
    digits.delete();
  endfunction

  function automatic void model_event(input logic [4:0] b);
    int k;
    if (b[4]) begin
      k = my * 6 + mx;
      if (k < 16) begin
        if (mode == 1'b1 || k <= 9) begin
          if (phase == PH_SHOWN) begin
            digits.delete(); digits.push_back(k); phase = PH_FIRST;
          end else if (digits.size() < MAX_DIGITS) begin
            digits.push_back(k);
          end
        end
      end else if (k <= 20) begin
        m_op = k - 16;
        if (phase != PH_SECOND) begin
          m_op1 = (phase == PH_SHOWN) ? int'(result) : screen_val();
          digits.delete();
          phase = PH_SECOND;
        end
      end else if (k == 21) begin
        digits.delete();
      end else if (k == 22) begin
        digits.delete(); m_op1 = 0; m_op2 = 0; m_op = 0; phase = PH_FIRST;
      end else if (phase == PH_SECOND) begin
        m_op2 = screen_val();
        go_q.push_back(m_op2);
        phase = PH_SHOWN;
      end
    end else if (b[3]) my = (my + 3) % 4;
    else if (b[2]) my = (my + 1) % 4;
    else if (b[1]) mx = (mx + 5) % 6;
    else if (b[0]) mx = (mx + 1) % 6;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.x = mx; s.y = my; s.op1 = m_op1; s.op2 = m_op2; s.op = m_op; s.scr = screen_val();
    return s;
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on sample strobes and on every calc_go pulse
  always @(negedge clk) begin
    snap_t e;
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard: sample with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        compare("pos_x", int'(pos_x), e.x);
        compare("pos_y", int'(pos_y), e.y);
        compare("op1", int'(op1), e.op1);
        compare("op2", int'(op2), e.op2);
        compare("op", int'(op), e.op);
        compare("input_screen", int'(input_screen), e.scr);
      end
    end
    if (calc_go) begin
      compare("calc_go_single", int'(prev_go), 0);
      if (go_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL calc_go_unexpected: got 1, expected 0 (t=%0t)", $time);
      end else begin
        compare("op2_at_go", int'(op2), go_q.pop_front());
      end
    end
    prev_go <= calc_go;
  end

  task automatic drive_btns(input logic [4:0] b);
    {btn_c, btn_u, btn_d, btn_l, btn_r} = b;
  endtask

  task automatic sample();
    exp_q.push_back(snap());
    @(posedge clk); #1 sample_req = 1'b1;
    @(posedge clk); #1 sample_req = 1'b0;
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk);
    drive_btns(b);
    model_event(b);
    @(negedge clk);
    drive_btns(5'b00000);
    sample();
  endtask

  task automatic press_key(input int k);
    int tx, ty;
    bit fwd;
    tx = k % 6; ty = k / 6;
    fwd = 1'($urandom_range(0, 1));
    while (mx != tx) press(fwd ? B_R : B_L);
    fwd = 1'($urandom_range(0, 1));
    while (my != ty) press(fwd ? B_D : B_U);
    press(B_C);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk); mode = m;
  endtask

  task automatic set_result(input logic [15:0] r);
    @(negedge clk); result = r;
  endtask

  // Reset asserted mid-stream with buttons held; check during and after
  task automatic do_reset(input logic [4:0] held);
    @(negedge clk);
    rst_n = 1'b0;
    drive_btns(held);
    model_reset();
    sample();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drive_btns(5'b00000);
    sample();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int k;
    logic [4:0] m;
    model_reset();
    sample();
    @(negedge clk); rst_n = 1'b1;
    sample();

    // Cursor walk with wrap, then U from row 0
    repeat (6) press(B_R);
    press(B_U);

    // Hex entry, fifth digit ignored
    set_mode(1'b1);
    press_key(1); press_key(2); press_key(10); press_key(11); press_key(12);

    // 5 + 3 =
    press_key(22);
    set_mode(1'b0);
    press_key(5); press_key(16); press_key(3); press_key(23);

    // Chain from result with &
    set_result(16'h0008);
    press_key(19);

    // C and R together: key only, cursor stays
    press_key(7);
    press(B_C | B_R);

    // U held across reset release; hex digit ignored in decimal mode
    do_reset(B_U);
    set_mode(1'b0);
    press_key(4); press_key(11);

    // Reset during entry with C held
    press_key(2);
    do_reset(B_C);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 12) begin
        k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(16, 23);
        press_key(k);
      end else if (sel < 15) begin
        m = 5'($urandom_range(1, 31));
        press(m);
      end else if (sel < 17) begin
        set_mode(1'($urandom_range(0, 1)));
      end else if (sel < 19) begin
        set_result(16'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        m = 5'($urandom_range(0, 31));
        do_reset(m);
      end else begin
        press_key(23);
      end
    end

    repeat (4) @(negedge clk);
    compare("pending_calc_go", go_q.size(), 0);
    compare("pending_samples", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
